// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: register offsets, CTRL/STATUS bit
// positions, FSM state encoding and the divider clamp helper.
package uart_rx_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_BAUD   = 4'h8;
  localparam logic [3:0] ADDR_RXDATA = 4'hC;

  localparam int CTRL_RX_EN   = 0;
  localparam int CTRL_INT_EN  = 1;
  localparam int STAT_VALID   = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_FERR    = 2;

  localparam logic [15:0] BAUD_MIN = 16'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] b);
    return (b < BAUD_MIN) ? BAUD_MIN : b;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO with wrap-around pointers and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic       full,
  output logic       empty,
  output logic [7:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with a RIB slave register interface. Define UART_RX_FIFO_EN
// to buffer FIFO_DEPTH bytes; otherwise a single holding register is used.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV_RST = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic        rx_pin,
  output logic        int_sig_o
);

  logic        rx_en, int_en, overrun, ferr;
  logic [15:0] baud;
  logic        rx_s1, rx_s2, rx_prev;
  rx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n, div, div_n, half_m1;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        push, stop_bad, pop, wr, rd, ovr_set;
  logic        buf_empty, buf_full;
  logic [7:0]  buf_rdata;
  logic [3:0]  offs;
  logic        unused_bits;

  assign offs        = addr_i[3:0];
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign ack_o       = req_i;
  assign pop         = rd && (offs == ADDR_RXDATA) && !buf_empty;
  assign ovr_set     = push && buf_full && !pop;
  assign half_m1     = {1'b0, div[15:1]} - 16'd1;
  assign unused_bits = ^{addr_i[31:4], data_i[31:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_pin;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      div   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      div   <= div_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  // Counters restart at each sampling point; the divider is latched at the start edge.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div;
    idx_n    = idx;
    shift_n  = shift;
    push     = 1'b0;
    stop_bad = 1'b0;
    if (!rx_en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_s2) begin
            div_n   = clamp_div(baud);
            cnt_n   = '0;
            idx_n   = '0;
            state_n = ST_START;
          end
        end
        ST_START: begin
          if (cnt == half_m1) begin
            cnt_n   = '0;
            state_n = rx_s2 ? ST_IDLE : ST_DATA;
          end else cnt_n = cnt + 16'd1;
        end
        ST_DATA: begin
          if (cnt == div - 16'd1) begin
            cnt_n   = '0;
            shift_n = {rx_s2, shift[7:1]};
            idx_n   = idx + 3'd1;
            if (idx == 3'd7) state_n = ST_STOP;
          end else cnt_n = cnt + 16'd1;
        end
        ST_STOP: begin
          if (cnt == div - 16'd1) begin
            cnt_n    = '0;
            push     = 1'b1;
            stop_bad = !rx_s2;
            state_n  = ST_IDLE;
          end else cnt_n = cnt + 16'd1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Flag set wins over a simultaneous write-1-to-clear so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_en     <= 1'b0;
      int_en    <= 1'b0;
      baud      <= 16'(BAUD_DIV_RST);
      overrun   <= 1'b0;
      ferr      <= 1'b0;
      int_sig_o <= 1'b0;
    end else begin
      if (wr && offs == ADDR_CTRL) begin
        rx_en  <= data_i[CTRL_RX_EN];
        int_en <= data_i[CTRL_INT_EN];
      end
      if (wr && offs == ADDR_BAUD) baud <= data_i[15:0];
      if (ovr_set) overrun <= 1'b1;
      else if (wr && offs == ADDR_STATUS && data_i[STAT_OVERRUN]) overrun <= 1'b0;
      if (push && stop_bad) ferr <= 1'b1;
      else if (wr && offs == ADDR_STATUS && data_i[STAT_FERR]) ferr <= 1'b0;
      int_sig_o <= int_en & (!buf_empty | overrun | ferr);
    end
  end

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (shift),
    .full  (buf_full),
    .empty (buf_empty),
    .rdata (buf_rdata)
  );
`else
  localparam int unused_depth = FIFO_DEPTH;
  logic       hold_valid;
  logic [7:0] hold_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= shift;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full  = hold_valid;
  assign buf_empty = !hold_valid;
  assign buf_rdata = hold_data;
`endif

  always_comb begin
    data_o = '0;
    if (req_i) begin
      case (offs)
        ADDR_CTRL: begin
          data_o[CTRL_RX_EN]  = rx_en;
          data_o[CTRL_INT_EN] = int_en;
        end
        ADDR_STATUS: begin
          data_o[STAT_VALID]   = !buf_empty;
          data_o[STAT_OVERRUN] = overrun;
          data_o[STAT_FERR]    = ferr;
        end
        ADDR_BAUD:   data_o[15:0] = baud;
        ADDR_RXDATA: if (!buf_empty) data_o[7:0] = buf_rdata;
        default:     data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: serial frame driver, bus driver, a queue-based
// reference of the receive buffer and flags, and a monitor on RXDATA reads.
module tb_uart_rx;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic [31:0] data_o;
  logic        ack_o;
  logic        rx_pin = 1'b1;
  logic        int_sig_o;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  bit m_ovr = 0, m_ferr = 0, m_int_en = 0;

  uart_rx #(.BAUD_DIV_RST(434), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .ack_o(ack_o), .rx_pin(rx_pin),
    .int_sig_o(int_sig_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", n, a, e);
    end
  endfunction

  // Monitor: every RXDATA read is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (req_i && !we_i && addr_i[3:0] == 4'hC) begin
      if (exp_q.size() != 0) chk("rxdata", data_o, {24'b0, exp_q.pop_front()});
      else chk("rxdata_empty", data_o, 32'h0);
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = {28'b0, a}; data_i = d;
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0; data_i = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = {28'b0, a};
    @(negedge clk);
    d = data_o;
    chk("ack", {31'b0, ack_o}, 32'h1);
    @(posedge clk); #1;
    req_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int per);
    @(posedge clk); #1 rx_pin = 1'b0;
    repeat (per) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_pin = b[i];
      repeat (per) @(posedge clk);
    end
    #1 rx_pin = stop_ok;
    repeat (per) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic model_push(input logic [7:0] b, input bit stop_ok);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else m_ovr = 1;
    if (!stop_ok) m_ferr = 1;
  endtask

  task automatic read_rx();
    logic [31:0] d;
    bus_read(4'hC, d);
  endtask

  task automatic check_reg(input string n, input logic [3:0] a, input logic [31:0] e);
    logic [31:0] d;
    bus_read(a, d);
    chk(n, d, e);
  endtask

  task automatic check_status();
    check_reg("status", 4'h4, {29'b0, m_ferr, m_ovr, exp_q.size() != 0});
  endtask

  task automatic check_int();
    repeat (2) @(posedge clk);
    #1;
    chk("int_sig", {31'b0, int_sig_o},
        {31'b0, m_int_en & ((exp_q.size() != 0) | m_ovr | m_ferr)});
  endtask

  task automatic clear_flags();
    bus_write(4'h4, 32'h6);
    m_ovr = 0; m_ferr = 0;
  endtask

  initial begin
    logic [7:0] rb;
    int op;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_int", {31'b0, int_sig_o}, 32'h0);
    chk("idle_data_o", data_o, 32'h0);
    check_reg("rst_ctrl", 4'h0, 32'h0);
    check_reg("rst_baud", 4'h8, 32'd434);
    check_status();
    read_rx();
    check_reg("unmapped", 4'h2, 32'h0);

    bus_write(4'h8, 32'hFFFF_0010);
    bus_write(4'h0, 32'h1);
    check_reg("baud16", 4'h8, 32'd16);
    check_reg("ctrl", 4'h0, 32'h1);

    // Basic frame, then read empties the buffer
    send_frame(8'hA5, 1, 16);
    model_push(8'hA5, 1);
    check_status();
    read_rx();
    check_status();

    // Short low glitch is rejected
    @(posedge clk); #1 rx_pin = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (30) @(posedge clk);
    check_status();

    // Framing error with interrupt enabled
    bus_write(4'h0, 32'h3);
    m_int_en = 1;
    send_frame(8'h3C, 0, 16);
    model_push(8'h3C, 0);
    check_int();
    check_status();
    read_rx();
    check_int();
    clear_flags();
    check_int();
    check_status();

    // Overflow the buffer with five frames
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1, 16);
      model_push(8'(i), 1);
    end
    check_status();
    check_int();
    for (int i = 0; i < 5; i++) read_rx();
    check_status();
    bus_write(4'h4, 32'h2);
    m_ovr = 0;
    check_status();
    check_int();

    // BAUD change mid-frame applies at the next start bit
    fork
      send_frame(8'h96, 1, 16);
      begin
        repeat (40) @(posedge clk);
        bus_write(4'h8, 32'd32);
      end
    join
    model_push(8'h96, 1);
    read_rx();
    check_reg("baud32", 4'h8, 32'd32);
    send_frame(8'h69, 1, 32);
    model_push(8'h69, 1);
    read_rx();
    check_status();
    bus_write(4'h8, 32'd16);

    // Disabling reception mid-frame drops the partial byte
    fork
      send_frame(8'h81, 1, 16);
      begin
        repeat (60) @(posedge clk);
        bus_write(4'h0, 32'h2);
      end
    join
    check_status();
    bus_write(4'h0, 32'h3);

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0, 1: begin
          bit ok;
          int per;
          rb  = 8'($urandom_range(0, 255));
          ok  = ($urandom_range(0, 3) != 0);
          per = ($urandom_range(0, 1) == 1) ? 24 : 16;
          bus_write(4'h8, per);
          send_frame(rb, ok, per);
          model_push(rb, ok);
        end
        2: read_rx();
        3: begin
          check_status();
          check_int();
        end
        default: clear_flags();
      endcase
    end
    for (int i = 0; i < DEPTH + 1; i++) read_rx();
    clear_flags();
    check_status();
    bus_write(4'h8, 32'd16);

    // Reset in the middle of a frame
    fork
      send_frame(8'hC3, 1, 16);
      begin
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_ovr = 0; m_ferr = 0; m_int_en = 0;
        chk("rst2_int", {31'b0, int_sig_o}, 32'h0);
        check_reg("rst2_ctrl", 4'h0, 32'h0);
        check_reg("rst2_baud", 4'h8, 32'd434);
        check_status();
      end
    join
    check_status();
    bus_write(4'h8, 32'd16);
    bus_write(4'h0, 32'h1);
    send_frame(8'h5A, 1, 16);
    model_push(8'h5A, 1);
    check_status();
    read_rx();
    check_status();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
